// File: rtl/udp_vlg_tx_arb.sv
// Round-robin arbiter that shares one UDP transmit engine among N clients.
// The grant is held for a whole packet, and a watchdog frees a stalled engine.
package udp_pkg;
  typedef struct packed {
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] dat;
  } udp_strm_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] dport;
    logic [15:0] sport;
    logic [15:0] len;
  } udp_meta_t;
endpackage

interface udp;
  import udp_pkg::*;
  udp_strm_t strm;
  udp_meta_t meta;
  logic      rdy;
  logic      req;
  logic      ack;
  logic      done;
  modport in_tx  (input strm, meta, rdy, output req, ack, done);
  modport out_tx (output strm, meta, rdy, input req, ack, done);
endinterface

module udp_vlg_tx_arb
  import udp_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  udp.in_tx            cli [N],
  udp.out_tx           eng,
  output logic [N-1:0] gnt,
  output logic         tmo
);
  localparam int            PW    = (N > 1) ? $clog2(N) : 1;
  localparam int            PW1   = PW + 1;
  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST  = PW'(N - 1);
  localparam logic [PW:0]   NW    = PW1'(N);
  localparam bit            WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [PW-1:0] gidx_reg, gidx_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic          acked_reg, acked_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic [N-1:0]  rdy_vec;
  logic [N-1:0]  cli_en;
  udp_strm_t     strm_arr [N];
  udp_meta_t     meta_arr [N];

  logic          busy;
  logic          force_err;

  assign busy   = (state_reg == BUSY);
  assign cli_en = busy ? gnt_reg : '0;

  // Engine handshakes reach only the granted client, and only while BUSY.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cli
      assign rdy_vec[gi]  = cli[gi].rdy;
      assign strm_arr[gi] = cli[gi].strm;
      assign meta_arr[gi] = cli[gi].meta;
      assign cli[gi].req  = cli_en[gi] & eng.req;
      assign cli[gi].ack  = cli_en[gi] & eng.ack;
      assign cli[gi].done = cli_en[gi] & eng.done;
    end
  endgenerate

  udp_strm_t strm_sel;
  udp_meta_t meta_sel;
  logic      rdy_sel;

  always_comb begin
    strm_sel = '0;
    meta_sel = '0;
    rdy_sel  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gnt_reg[i]) begin
        strm_sel = strm_arr[i];
        meta_sel = meta_arr[i];
        rdy_sel  = rdy_vec[i];
      end
    end
  end

  // Rotate requests so that bit 0 is the client at ptr, then take the lowest set bit.
  logic [N-1:0]  rdy_rot;
  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_off;
  logic [PW-1:0] pick_idx;
  logic [PW:0]   pick_sum;
  logic          pick_any;
  logic [PW-1:0] ptr_inc;

  assign rdy_rot = N'({rdy_vec, rdy_vec} >> ptr_reg);
  assign ptr_inc = (gidx_reg == LAST) ? '0 : gidx_reg + PW'(1);

  always_comb begin
    pick_any = 1'b0;
    pick_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rdy_rot[k]) begin
        pick_any = 1'b1;
        pick_off = PW'(k);
      end
    end
    pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
    pick_idx = (pick_sum >= NW) ? PW'(pick_sum - NW) : PW'(pick_sum);
    pick_oh  = '0;
    for (int i = 0; i < N; i++) begin
      pick_oh[i] = pick_any && (pick_idx == PW'(i));
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    gidx_next  = gidx_reg;
    ptr_next   = ptr_reg;
    acked_next = acked_reg;
    cnt_next   = cnt_reg;
    tmo        = 1'b0;
    force_err  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (pick_any) begin
          gnt_next   = pick_oh;
          gidx_next  = pick_idx;
          acked_next = 1'b0;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        cnt_next = (cnt_reg == TMAX) ? cnt_reg : cnt_reg + CW'(1);
        if (eng.ack) acked_next = 1'b1;
        // done wins over a coincident watchdog hit; ack in the same cycle blocks withdrawal
        if (eng.done || (!rdy_sel && !acked_reg && !eng.ack)) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_inc;
          acked_next = 1'b0;
        end else if (WD_EN && (cnt_reg == TMAX)) begin
          tmo        = 1'b1;
          force_err  = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (!eng.req) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = ptr_inc;
          acked_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= '0;
      acked_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      gidx_reg  <= gidx_next;
      ptr_reg   <= ptr_next;
      acked_reg <= acked_next;
      cnt_reg   <= cnt_next;
    end
  end

  udp_strm_t strm_out;

  always_comb begin
    strm_out = busy ? strm_sel : '0;
    if (force_err) begin
      strm_out.err = 1'b1;
      strm_out.val = 1'b0;
    end
  end

  assign eng.strm = strm_out;
  assign eng.meta = busy ? meta_sel : '0;
  assign eng.rdy  = busy & rdy_sel;
  assign gnt      = gnt_reg;

endmodule

// File: tb/tb_udp_vlg_tx_arb.sv
// Directed bench for udp_vlg_tx_arb: one N=2 instance for the single-client packet,
// one N=3/TIMEOUT=20 instance for round-robin, withdraw, watchdog, reset and tie cases.
module tb_udp_vlg_tx_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  udp ca [2] ();
  udp ea ();
  udp cb [3] ();
  udp eb ();

  logic [1:0] gnt_a;
  logic       tmo_a;
  logic [2:0] gnt_b;
  logic       tmo_b;

  udp_vlg_tx_arb #(.N(2), .TIMEOUT(100)) u_a (
    .clk(clk), .rst(rst), .cli(ca), .eng(ea), .gnt(gnt_a), .tmo(tmo_a)
  );
  udp_vlg_tx_arb #(.N(3), .TIMEOUT(20)) u_b (
    .clk(clk), .rst(rst), .cli(cb), .eng(eb), .gnt(gnt_b), .tmo(tmo_b)
  );

  logic [1:0] rdy_a, val_a, req_oa, ack_oa, done_oa;
  logic [7:0] dat_a [2];
  logic [2:0] rdy_b, val_b, req_ob, ack_ob, done_ob;
  logic [7:0] dat_b [3];
  logic       ereq_a, eack_a, edone_a, ereq_b, eack_b, edone_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ca
    assign ca[gi].rdy        = rdy_a[gi];
    assign ca[gi].strm.val   = val_a[gi];
    assign ca[gi].strm.sof   = 1'b0;
    assign ca[gi].strm.eof   = 1'b0;
    assign ca[gi].strm.err   = 1'b0;
    assign ca[gi].strm.dat   = dat_a[gi];
    assign ca[gi].meta.ip    = 32'h0A00_0010 + 32'(gi);
    assign ca[gi].meta.dport = 16'd123;
    assign ca[gi].meta.sport = 16'd4000;
    assign ca[gi].meta.len   = 16'd17;
    assign req_oa[gi]        = ca[gi].req;
    assign ack_oa[gi]        = ca[gi].ack;
    assign done_oa[gi]       = ca[gi].done;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cb
    assign cb[gi].rdy        = rdy_b[gi];
    assign cb[gi].strm.val   = val_b[gi];
    assign cb[gi].strm.sof   = 1'b0;
    assign cb[gi].strm.eof   = 1'b0;
    assign cb[gi].strm.err   = 1'b0;
    assign cb[gi].strm.dat   = dat_b[gi];
    assign cb[gi].meta.ip    = 32'h0A00_0020 + 32'(gi);
    assign cb[gi].meta.dport = 16'd67;
    assign cb[gi].meta.sport = 16'd68;
    assign cb[gi].meta.len   = 16'd8;
    assign req_ob[gi]        = cb[gi].req;
    assign ack_ob[gi]        = cb[gi].ack;
    assign done_ob[gi]       = cb[gi].done;
  end

  assign ea.req  = ereq_a;
  assign ea.ack  = eack_a;
  assign ea.done = edone_a;
  assign eb.req  = ereq_b;
  assign eb.ack  = eack_b;
  assign eb.done = edone_b;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Ack, done, then an idle cycle with all requests dropped.
  task automatic b_finish(input string tag);
    tick(); eack_b = 1'b1; smp();
    tick(); eack_b = 1'b0; edone_b = 1'b1; smp();
    tick(); edone_b = 1'b0; rdy_b = '0; smp();
    chk(tag, int'(gnt_b), 0);
    $display("B packet %s complete", tag);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1;
    rdy_a = '0; val_a = '0; rdy_b = 3'b111; val_b = '0;
    for (int i = 0; i < 2; i++) dat_a[i] = '0;
    for (int i = 0; i < 3; i++) dat_b[i] = '0;
    ereq_a = 0; eack_a = 0; edone_a = 0;
    ereq_b = 0; eack_b = 0; edone_b = 0;

    // reset holds everything idle even with requests pending
    repeat (3) @(posedge clk);
    smp();
    chk("rst_gnt_a", int'(gnt_a), 0);
    chk("rst_gnt_b", int'(gnt_b), 0);
    chk("rst_tmo_b", int'(tmo_b), 0);
    chk("rst_erdy_b", int'(eb.rdy), 0);
    chk("rst_strm_b", int'(eb.strm), 0);
    chk("rst_ip_b", int'(eb.meta.ip), 0);
    rst = 1'b0;
    rdy_b = '0;

    // single client on the N=2 instance
    for (int c = 0; c < 34; c++) begin
      tick();
      rdy_a[0] = (c >= 10 && c <= 31);
      eack_a   = (c == 12);
      ereq_a   = (c >= 14 && c <= 30);
      edone_a  = (c == 31);
      val_a[0] = ereq_a;
      dat_a[0] = 8'(c * 7 + 3);
      smp();
      chk("a_gnt", int'(gnt_a), (c >= 11 && c <= 31) ? 1 : 0);
      chk("a_erdy", int'(ea.rdy), (c >= 11 && c <= 31) ? 1 : 0);
      chk("a_req0", int'(req_oa[0]), (c >= 14 && c <= 30) ? 1 : 0);
      chk("a_ack0", int'(ack_oa[0]), (c == 12) ? 1 : 0);
      chk("a_done0", int'(done_oa[0]), (c == 31) ? 1 : 0);
      chk("a_cli1", int'({req_oa[1], ack_oa[1], done_oa[1]}), 0);
      chk("a_tmo", int'(tmo_a), 0);
      if (c >= 14 && c <= 30) begin
        chk("a_dat", int'(ea.strm.dat), (c * 7 + 3) & 255);
        chk("a_val", int'(ea.strm.val), 1);
      end else if (c < 11 || c > 31) begin
        chk("a_idle_strm", int'(ea.strm), 0);
      end
      if (c == 20) chk("a_ip", int'(ea.meta.ip), 32'h0A00_0010);
    end
    $display("A packet client0 granted 11..31 complete");

    // round-robin with all three clients requesting
    tick(); rdy_b = 3'b111; smp();
    chk("b_pre", int'(gnt_b), 0);
    tick(); smp();
    for (int k = 0; k < 6; k++) begin
      chk("b_gnt", int'(gnt_b), 1 << (k % 3));
      tick(); eack_b = 1'b1; smp();
      chk("b_ack", int'(ack_ob), 1 << (k % 3));
      tick(); eack_b = 1'b0; edone_b = 1'b1; smp();
      chk("b_done", int'(done_ob), 1 << (k % 3));
      tick(); edone_b = 1'b0; if (k == 5) rdy_b = '0; smp();
      chk("b_idle", int'(gnt_b), 0);
      $display("B packet %0d gnt client %0d", k, k % 3);
      tick(); smp();
    end
    chk("b_end", int'(gnt_b), 0);

    // withdraw before ack: client 1 drops rdy two cycles after grant
    tick(); rdy_b = 3'b010; smp();
    tick(); smp(); chk("c_gnt", int'(gnt_b), 2);
    tick(); smp(); chk("c_hold", int'(gnt_b), 2);
    tick(); rdy_b = '0; smp();
    chk("c_erdy", int'(eb.rdy), 0);
    chk("c_tmo", int'(tmo_b), 0);
    tick(); rdy_b = 3'b111; smp(); chk("c_rel", int'(gnt_b), 0);
    tick(); smp(); chk("c_ptr", int'(gnt_b), 4);
    $display("C withdraw released, next grant client 2");
    b_finish("c_fin");

    // watchdog: acked, never done
    tick(); rdy_b = 3'b001; val_b[0] = 1'b1; dat_b[0] = 8'hA5; smp();
    tick(); smp(); chk("d_gnt", int'(gnt_b), 1);
    for (int j = 1; j < 20; j++) begin
      tick(); eack_b = (j == 1); smp();
      chk("d_tmo_lo", int'(tmo_b), 0);
    end
    tick(); eack_b = 1'b0; smp();
    chk("d_tmo", int'(tmo_b), 1);
    chk("d_err", int'(eb.strm.err), 1);
    chk("d_val", int'(eb.strm.val), 0);
    chk("d_gnt_hit", int'(gnt_b), 1);
    tick(); eack_b = 1'b1; smp();
    chk("d_fl_gnt", int'(gnt_b), 1);
    chk("d_fl_erdy", int'(eb.rdy), 0);
    chk("d_fl_tmo", int'(tmo_b), 0);
    chk("d_fl_ack", int'(ack_ob), 0);
    chk("d_fl_strm", int'(eb.strm), 0);
    tick(); eack_b = 1'b0; rdy_b = 3'b011; val_b[0] = 1'b0; smp();
    chk("d_rel", int'(gnt_b), 0);
    tick(); smp(); chk("d_ptr", int'(gnt_b), 2);
    $display("D watchdog flushed, next grant client 1");
    b_finish("d_fin");

    // reset in the middle of client 2's payload
    tick(); rdy_b = 3'b111; smp();
    tick(); smp(); chk("e_gnt", int'(gnt_b), 4);
    tick(); eack_b = 1'b1; smp();
    tick(); eack_b = 1'b0; ereq_b = 1'b1; val_b[2] = 1'b1; dat_b[2] = 8'h5A; smp();
    chk("e_dat", int'(eb.strm.dat), 8'h5A);
    chk("e_req2", int'(req_ob), 4);
    tick(); rst = 1'b1; smp();
    tick(); rst = 1'b0; smp();
    chk("e_gnt0", int'(gnt_b), 0);
    chk("e_erdy", int'(eb.rdy), 0);
    chk("e_strm", int'(eb.strm), 0);
    chk("e_reqo", int'(req_ob), 0);
    tick(); ereq_b = 1'b0; val_b[2] = 1'b0; smp();
    chk("e_first", int'(gnt_b), 1);
    $display("E reset mid-packet, first grant client 0");
    b_finish("e_fin");

    // done exactly when the watchdog count hits TIMEOUT
    tick(); rdy_b = 3'b010; smp();
    tick(); smp(); chk("f_gnt", int'(gnt_b), 2);
    for (int j = 1; j < 20; j++) begin
      tick(); eack_b = (j == 1); smp();
      chk("f_tmo_lo", int'(tmo_b), 0);
    end
    tick(); eack_b = 1'b0; edone_b = 1'b1; smp();
    chk("f_tmo", int'(tmo_b), 0);
    chk("f_err", int'(eb.strm.err), 0);
    chk("f_done1", int'(done_ob), 2);
    tick(); edone_b = 1'b0; rdy_b = '0; smp();
    chk("f_rel", int'(gnt_b), 0);
    chk("f_tmo_after", int'(tmo_b), 0);
    $display("F done/timeout tie released normally");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
